// File: rtl/bchecc_sfr_seq.sv
// bchecc_sfr_seq: SFR initiator that runs one BCH ECC operation per start request.
// Sequence: config write (0x4), control write (0x0), status polling (0x8) until
// busy clears or the poll budget runs out, then a done pulse with the status byte.
// Optional feature macro: BCHECC_SEQ_CLRFAIL_EN adds a write of 0 to 0x8 after
// every non-timeout completion to clear the sticky correct_fail status bit.
module bchecc_sfr_seq #(
  parameter int POLL_GAP  = 4,
  parameter int MAX_POLLS = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [9:0]  cfg_i,
  input  logic [3:0]  ctrl_i,
  input  logic [31:0] sfr_rdata_i,
  output logic        sfr_en_o,
  output logic        sfr_rd_o,
  output logic        sfr_wr_o,
  output logic [1:0]  sfr_size_o,
  output logic [3:0]  sfr_addr_o,
  output logic [31:0] sfr_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  stat_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_CFG   = 3'd1,
    S_WR_CTRL  = 3'd2,
    S_WAIT     = 3'd3,
    S_RD_STAT  = 3'd4,
`ifdef BCHECC_SEQ_CLRFAIL_EN
    S_CLR_FAIL = 3'd6,
`endif
    S_DONE     = 3'd5
  } state_t;

  localparam logic [7:0]  GAP_LOAD  = 8'(POLL_GAP - 1);
  localparam logic [10:0] MAX_POLL  = 11'(MAX_POLLS);

  state_t      state_q;
  state_t      state_d;
  logic [9:0]  cfg_q;
  logic [3:0]  ctrl_q;
  logic [7:0]  gap_q;
  logic [9:0]  poll_q;
  logic [7:0]  stat_q;
  logic        timeout_q;
  logic [10:0] poll_inc;
  logic        slave_busy;
  logic        polls_left;
  logic        unused_rdata;

  // Poll accounting is done one bit wider so MAX_POLLS = 1023 compares cleanly.
  assign poll_inc     = {1'b0, poll_q} + 11'd1;
  assign polls_left   = (poll_inc < MAX_POLL);
  assign slave_busy   = sfr_rdata_i[0];
  assign unused_rdata = ^sfr_rdata_i[31:8];

  assign busy_o    = (state_q != S_IDLE);
  assign stat_o    = stat_q;
  assign timeout_o = timeout_q;

  // State register; reset forces IDLE, which also zeroes every decoded output.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection and the single-cycle SFR access decoded from the state.
  always_comb begin
    state_d     = state_q;
    sfr_en_o    = 1'b0;
    sfr_rd_o    = 1'b0;
    sfr_wr_o    = 1'b0;
    sfr_size_o  = 2'b00;
    sfr_addr_o  = 4'h0;
    sfr_wdata_o = 32'h0;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_WR_CFG;
      end
      S_WR_CFG: begin
        sfr_en_o    = 1'b1;
        sfr_wr_o    = 1'b1;
        sfr_size_o  = 2'b10;
        sfr_addr_o  = 4'h4;
        sfr_wdata_o = {22'b0, cfg_q};
        state_d     = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        sfr_en_o    = 1'b1;
        sfr_wr_o    = 1'b1;
        sfr_addr_o  = 4'h0;
        sfr_wdata_o = {4{4'h0, ctrl_q}};
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (gap_q == 8'd0) state_d = S_RD_STAT;
      end
      S_RD_STAT: begin
        sfr_en_o   = 1'b1;
        sfr_rd_o   = 1'b1;
        sfr_addr_o = 4'h8;
        if (slave_busy) begin
          state_d = polls_left ? S_WAIT : S_DONE;
        end else begin
`ifdef BCHECC_SEQ_CLRFAIL_EN
          state_d = S_CLR_FAIL;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef BCHECC_SEQ_CLRFAIL_EN
      S_CLR_FAIL: begin
        sfr_en_o   = 1'b1;
        sfr_wr_o   = 1'b1;
        sfr_addr_o = 4'h8;
        state_d    = S_DONE;
      end
`endif
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, gap/poll counters and the held status/timeout results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q     <= 10'h0;
      ctrl_q    <= 4'h0;
      gap_q     <= 8'h0;
      poll_q    <= 10'h0;
      stat_q    <= 8'h0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cfg_q     <= cfg_i;
            ctrl_q    <= ctrl_i;
            poll_q    <= 10'h0;
            stat_q    <= 8'h0;
            timeout_q <= 1'b0;
          end
        end
        S_WR_CTRL: gap_q <= GAP_LOAD;
        S_WAIT: begin
          if (gap_q != 8'd0) gap_q <= gap_q - 8'd1;
        end
        S_RD_STAT: begin
          stat_q <= sfr_rdata_i[7:0];
          poll_q <= poll_inc[9:0];
          if (slave_busy) begin
            if (polls_left) gap_q     <= GAP_LOAD;
            else            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
